// File: rtl/register_file_if.sv
// Register file bus: two read ports, one write port, ready.
// Master drives indices and write-back, slave returns data.
interface register_file_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] readReg1;
  logic [ADDR_WIDTH-1:0] readReg2;
  logic [ADDR_WIDTH-1:0] writeReg;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  regWrite;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic                  ready;

  modport master (
    output readReg1, readReg2,
    output writeReg, writeData, regWrite,
    input  readData1, readData2, ready
  );

  modport slave (
    input  readReg1, readReg2,
    input  writeReg, writeData, regWrite,
    output readData1, readData2, ready
  );
endinterface

// File: rtl/register_file.sv
// Integer register file, x0 hardwired to zero, cleared after reset.
// REGFILE_BYPASS_EN adds write-through forwarding on both read ports.
module register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(NUM_REGS-1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_clrIdx;
  logic [ADDR_WIDTH-1:0] w_clrIdx_next;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_ready;
  logic                  w_byp1;
  logic                  w_byp2;

  // State and clear-index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CLEAR;
      r_clrIdx <= ADDR_WIDTH'(1);
    end else begin
      r_state  <= w_next;
      r_clrIdx <= w_clrIdx_next;
    end
  end

  // Next state and shared write-port mux (clear vs write-back)
  always_comb begin
    w_next        = r_state;
    w_clrIdx_next = r_clrIdx;
    w_we          = 1'b0;
    w_waddr       = bus.writeReg;
    w_wdata       = bus.writeData;
    unique case (r_state)
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clrIdx;
        w_wdata = '0;
        if (r_clrIdx == LAST_IDX)
          w_next = READY;
        else
          w_clrIdx_next = r_clrIdx + ADDR_WIDTH'(1);
      end
      READY: begin
        w_we = bus.regWrite &&
               (bus.writeReg != '0);
      end
    endcase
  end

  // Single write port; the reset edge never writes
  always_ff @(posedge clk) begin
    if (!rst && w_we)
      r_regs[w_waddr] <= w_wdata;
  end

  assign w_ready   = (r_state == READY);
  assign bus.ready = w_ready;

`ifdef REGFILE_BYPASS_EN
  // Forward same-cycle write-back to matching read ports
  always_comb begin
    w_byp1 = bus.regWrite && w_ready &&
             (bus.writeReg != '0) &&
             (bus.writeReg == bus.readReg1);
    w_byp2 = bus.regWrite && w_ready &&
             (bus.writeReg != '0) &&
             (bus.writeReg == bus.readReg2);
  end
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  // Combinational reads; zero for x0 and while clearing
  always_comb begin
    bus.readData1 = '0;
    bus.readData2 = '0;
    if (w_ready && bus.readReg1 != '0)
      bus.readData1 = w_byp1 ? bus.writeData
                             : r_regs[bus.readReg1];
    if (w_ready && bus.readReg2 != '0)
      bus.readData2 = w_byp2 ? bus.writeData
                             : r_regs[bus.readReg2];
  end
endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against an array model.
// Model tracks clear progress as a count of non-reset edges.
module tb_register_file;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model [32];
  int            clr_edges = 0;
  bit            known = 0;
  logic [DW-1:0] last_rd1;
  logic [DW-1:0] last_rd2;
  logic          last_rdy;

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int rr);
    bit rdy;
    rdy = known && (clr_edges >= 31);
    if (!rdy || rr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.regWrite && bus.writeReg != 0 &&
        int'(bus.writeReg) == rr)
      return bus.writeData;
`endif
    return model[rr];
  endfunction

  task automatic cyc(input logic r, input int r1, input int r2,
                     input int wr, input logic [DW-1:0] wd,
                     input logic we);
    bit rdy;
    @(negedge clk);
    rst           = r;
    bus.readReg1  = AW'(r1);
    bus.readReg2  = AW'(r2);
    bus.writeReg  = AW'(wr);
    bus.writeData = wd;
    bus.regWrite  = we;
    #1;
    last_rd1 = bus.readData1;
    last_rd2 = bus.readData2;
    last_rdy = bus.ready;
    if (known) begin
      rdy = (clr_edges >= 31);
      check("ready", {63'b0, bus.ready}, {63'b0, rdy});
      check("rd1", bus.readData1, exp_rd(r1));
      check("rd2", bus.readData2, exp_rd(r2));
    end
    @(posedge clk);
    if (r) begin
      known = 1;
      clr_edges = 0;
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (known) begin
      if (clr_edges < 31) clr_edges++;
      else if (we && wr != 0) model[wr] = wd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5, 0, 0, '0, 0);
  endtask

  initial begin
    bus.readReg1 = '0; bus.readReg2 = '0;
    bus.writeReg = '0; bus.writeData = '0;
    bus.regWrite = 1'b0;

    // reset and clear: 31 non-reset edges before ready
    cyc(1, 5, 0, 0, '0, 0);
    cyc(1, 5, 0, 0, '0, 0);
    for (int i = 0; i < 31; i++) begin
      cyc(0, 5, 0, 0, '0, 0);
      check("clr_busy", {63'b0, last_rdy}, 64'd0);
    end
    cyc(0, 5, 0, 0, '0, 0);
    check("clr_done", {63'b0, last_rdy}, 64'd1);
    check("clr_zero", last_rd1, 64'd0);

    // write/read operands
    cyc(0, 0, 0, 3, 64'd10, 1);
    cyc(0, 0, 0, 4, 64'd5, 1);
    cyc(0, 3, 4, 0, '0, 0);
    check("opA", last_rd1, 64'd10);
    check("opB", last_rd2, 64'd5);

    // x0 protection
    cyc(0, 0, 0, 0, '1, 1);
    cyc(0, 0, 0, 0, '0, 0);
    check("x0", last_rd1, 64'd0);

    // write ignored during clear
    cyc(1, 0, 0, 0, '0, 0);
    idle(3);
    cyc(0, 0, 31, 31, 64'd7, 1);
    idle(28);
    cyc(0, 0, 31, 0, '0, 0);
    check("clr_drop", last_rd2, 64'd0);
    check("clr_drop_rdy", {63'b0, last_rdy}, 64'd1);

    // reset mid-clear restarts full sequence
    cyc(1, 0, 0, 0, '0, 0);
    idle(10);
    cyc(1, 0, 0, 0, '0, 0);
    idle(30);
    cyc(0, 0, 0, 0, '0, 0);
    check("mid_busy", {63'b0, last_rdy}, 64'd0);
    cyc(0, 0, 0, 0, '0, 0);
    check("mid_done", {63'b0, last_rdy}, 64'd1);

    // same-cycle read/write
    cyc(0, 0, 0, 7, 64'd2, 1);
    cyc(0, 7, 7, 7, 64'd9, 1);
`ifdef REGFILE_BYPASS_EN
    check("rw_same", last_rd1, 64'd9);
`else
    check("rw_same", last_rd1, 64'd2);
`endif
    check("rw_ports", last_rd2, last_rd1);
    cyc(0, 7, 0, 0, '0, 0);
    check("rw_after", last_rd1, 64'd9);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom};
      cyc(($urandom_range(0, 99) == 0),
          $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), d,
          logic'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file for the unicycle processor.
- Sits directly upstream of the ALU: readData1 drives ALU operand A, and readData2 drives operand B (register path) in the same cycle.
- Write-back arrives from the ALU result or the memory mux and is committed on the clock edge.
- Register 0 is hardwired to zero.
- After reset, a clear sequencer zeroes registers 1..31 one per cycle through the single write port, so the array maps to single-write-port RAM.

Parameters:
- DATA_WIDTH, 64, width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high; sampled only on the rising edge of clk.
- readReg1  input  ADDR_WIDTH  index for read port 1 (rs1).
- readReg2  input  ADDR_WIDTH  index for read port 2 (rs2).
- writeReg  input  ADDR_WIDTH  write-back index (rd).
- writeData  input  DATA_WIDTH  write-back value.
- regWrite  input  1  write enable from the control unit.
- readData1  output  DATA_WIDTH  contents of readReg1; feeds ALU A.
- readData2  output  DATA_WIDTH  contents of readReg2; feeds ALU B.
- ready  output  1  high when the clear sequence is done and the file accepts writes.

Behaviour:
- State machine: CLEAR, READY. A counter clrIdx of width ADDR_WIDTH tracks the clear sequence.
- Reset, rst=1 at an edge:
  - state <= CLEAR, clrIdx <= 1.
  - No array write occurs on that edge.
  - Any pending regWrite is dropped.
  - ready=0 from that edge on.
- CLEAR, rst=0 at an edge:
  - reg[clrIdx] <= 0.
  - If clrIdx==NUM_REGS-1: state <= READY. Otherwise clrIdx <= clrIdx+1.
  - Exactly NUM_REGS-1 (31) non-reset edges are needed; ready rises after the 31st.
  - rst held high keeps the sequence at clrIdx=1; no progress.
- Reset mid-clear: clrIdx restarts at 1 and the full 31-cycle sequence repeats.
- Reset in READY: same as any reset, and the clear sequence reruns.
- ready = (state==READY). It is a registered state decode with no combinational path from inputs.
- Writes:
  - reg[writeReg] <= writeData at the edge where regWrite=1, ready=1, rst=0 and writeReg!=0.
  - Writes to index 0 are silently discarded.
  - Writes with ready=0 are discarded; regWrite does not stall or queue.
- Reads: combinational, zero latency.
  - readDataN = 0 if readRegN==0 or ready==0; otherwise reg[readRegN].
  - Outputs are forced to 0 while clearing, so stale or uninitialised contents never reach the ALU.
- Same-edge read/write, no bypass build: a read of writeReg returns the old value until the edge, then the new value.
- Both ports reading the same index return identical data.
- Widths:
  - No arithmetic on data; values are stored and returned bit-exact.
  - clrIdx never wraps; the sequence terminates at NUM_REGS-1.
- Reset values:
  - ready=0.
  - readData1 and readData2 = 0 from the reset edge until READY.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through bypass on each read port.
  - If regWrite=1, ready=1, writeReg!=0 and readRegN==writeReg, then readDataN = writeData combinationally in the same cycle.
  - Index 0 and ready=0 still force 0.
- Not defined: no bypass; reads return array contents only, and a written value becomes visible after the write edge.

Test Plan:
- Reset and clear:
  - Stimulus: rst=1 for 2 cycles, then 0; probe readReg1=5 every cycle.
  - Required: ready=0 and readData1=0 for 31 edges after rst falls; ready=1 after the 31st edge; readData1=0 once ready.
- Write/read:
  - Stimulus: once ready, regWrite=1, writeReg=3, writeData=10; next cycle writeReg=4, writeData=5; then readReg1=3, readReg2=4.
  - Required: readData1=10, readData2=5 (ALU A/B operands 10 and 5).
- x0 protection:
  - Stimulus: regWrite=1, writeReg=0, writeData=64'hFFFF_FFFF_FFFF_FFFF; then readReg1=0.
  - Required: readData1=0.
- Write ignored during clear:
  - Stimulus: rst pulse, then 3 cycles later regWrite=1, writeReg=31, writeData=7.
  - Required: after ready, readReg2=31 gives readData2=0.
- Reset mid-clear:
  - Stimulus: rst pulse, 10 clear cycles, rst pulse again.
  - Required: ready stays 0 for a further 31 edges after the second pulse, not 21.
- Same-cycle read/write:
  - Stimulus: reg 7 holds 2; regWrite=1, writeReg=7, writeData=9, readReg1=7.
  - Required, REGFILE_BYPASS_EN undefined: readData1=2 before the edge and 9 after.
  - Required, REGFILE_BYPASS_EN defined: readData1=9 in the same cycle.
